// File: rtl/int_to_float.sv
// Iterative signed-integer to float converter producing {exp[7:0], mant[23:0]},
// value = mant * 2^exp, both fields two's complement, mantissa truncated toward -inf.
module int_to_float #(
    parameter int IN_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_int,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_fp,
    output logic            out_inexact
);

    // Exponent that makes the top 24 bits of W the mantissa without shifting.
    localparam logic signed [7:0] E_INIT = 8'(IN_W - 24);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic signed [IN_W-1:0] w;
    logic signed [IN_W-1:0] w_nxt;
    logic signed [IN_W-1:0] w_shl;
    logic signed [7:0]      e;
    logic signed [7:0]      e_nxt;
    logic [31:0]            fp_nxt;
    logic                   inexact_nxt;

    function automatic logic is_norm(input logic [IN_W-1:0] x);
        return x[IN_W-1] ^ x[IN_W-2];
    endfunction

    function automatic logic [23:0] trunc_mant(input logic [IN_W-1:0] x);
        return x[IN_W-1 -: 24];
    endfunction

    function automatic logic trunc_inexact(input logic [IN_W-1:0] x);
        return |x[IN_W-25:0];
    endfunction

    assign w_shl     = {w[IN_W-2:0], 1'b0};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        state_nxt   = state;
        w_nxt       = w;
        e_nxt       = e;
        fp_nxt      = out_fp;
        inexact_nxt = out_inexact;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    w_nxt = in_int;
                    e_nxt = E_INIT;
                    if (in_int == '0) begin
                        // Zero never normalises; report it with a zero exponent.
                        e_nxt       = '0;
                        fp_nxt      = '0;
                        inexact_nxt = 1'b0;
                        state_nxt   = DONE;
                    end else if (is_norm(in_int)) begin
                        fp_nxt      = {E_INIT, trunc_mant(in_int)};
                        inexact_nxt = trunc_inexact(in_int);
                        state_nxt   = DONE;
                    end else begin
                        state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                w_nxt = w_shl;
                e_nxt = e - 8'sd1;
                if (is_norm(w_shl)) begin
                    fp_nxt      = {e_nxt, trunc_mant(w_shl)};
                    inexact_nxt = trunc_inexact(w_shl);
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            w           <= '0;
            e           <= '0;
            out_fp      <= '0;
            out_inexact <= 1'b0;
        end else begin
            state       <= state_nxt;
            w           <= w_nxt;
            e           <= e_nxt;
            out_fp      <= fp_nxt;
            out_inexact <= inexact_nxt;
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float: result word, inexact flag and latency,
// plus backpressure and mid-conversion reset sequences.
module tb_int_to_float;

    localparam int IN_W = 32;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_int;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_fp;
    logic            out_inexact;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [31:0] in_int;
        logic [31:0] fp;
        logic        inexact;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    int_to_float #(.IN_W(IN_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_int      (in_int),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_fp      (out_fp),
        .out_inexact (out_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Input must already be presented; counts edges with the accepting edge as 1.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic release_output();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic convert(input string name, input vec_t v);
        int lat;
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_int   = v.in_int;
        in_valid = 1'b1;
        wait_result(lat);
        chk({name, " latency"}, 32'(lat), 32'(v.lat));
        chk({name, " out_fp"}, out_fp, v.fp);
        chk({name, " inexact"}, 32'(out_inexact), 32'(v.inexact));
        release_output();
    endtask

    initial begin
        int lat;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_int    = '0;
        out_ready = 1'b0;

        vecs[0]  = '{32'h00000005, 32'hEC500000, 1'b0, 29};
        vecs[1]  = '{32'h00000000, 32'h00000000, 1'b0, 1};
        vecs[2]  = '{32'h80000000, 32'h08800000, 1'b0, 1};
        vecs[3]  = '{32'h7FFFFFFF, 32'h087FFFFF, 1'b1, 1};
        vecs[4]  = '{32'hFFFFFFFF, 32'hE9800000, 1'b0, 32};
        vecs[5]  = '{32'h00000001, 32'hEA400000, 1'b0, 31};
        vecs[6]  = '{32'h12345678, 32'h0648D159, 1'b1, 3};
        vecs[7]  = '{32'hFFFFFFFB, 32'hECB00000, 1'b0, 29};
        vecs[8]  = '{32'h40000000, 32'h08400000, 1'b0, 1};
        vecs[9]  = '{32'hC0000000, 32'h07800000, 1'b0, 2};
        vecs[10] = '{32'h000001FF, 32'hF27FC000, 1'b0, 23};
        vecs[11] = '{32'h00FFFFFF, 32'h017FFFFF, 1'b1, 8};

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_fp", out_fp, 32'h0);
        chk("reset inexact", 32'(out_inexact), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            convert($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: a new input waits while the result is held.
        in_int   = 32'h12345678;
        in_valid = 1'b1;
        wait_result(lat);
        chk("bp first latency", 32'(lat), 32'd3);
        in_int   = 32'h00000005;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("bp out_fp held", out_fp, 32'h0648D159);
            chk("bp out_valid held", 32'(out_valid), 32'd1);
            chk("bp in_ready low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp back to idle", 32'(in_ready), 32'd1);
        chk("bp out_valid drop", 32'(out_valid), 32'd0);
        wait_result(lat);
        chk("bp second latency", 32'(lat), 32'd29);
        chk("bp second out_fp", out_fp, 32'hEC500000);
        release_output();

        // Reset in the middle of a long normalisation.
        in_int   = 32'h00000001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid norm out_valid", 32'(out_valid), 32'd0);
        chk("mid norm in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_fp", out_fp, 32'h0);
        chk("rst inexact", 32'(out_inexact), 32'd0);
        convert("after rst", vecs[3]);
        convert("after rst2", vecs[6]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
